otter_io_responder: RTL
=======================

// Module: otter_io_responder
// PURPOSE
//  Responder end of the OTTER memory-stage IOBUS: decodes IOBUS_ADDR/IOBUS_OUT/IOBUS_WR and returns IOBUS_IN.
//  The memory stage drives these from MEM_aluResult, MEM_DIN2 and IO_WR when the access falls in IO space.
//  Holds the board-facing LED and 7-seg registers, a synchronised switch input, and a prescaled compare timer.
//  The timer raises INTR toward the pipeline.
// PARAMETERS
//  IO_BASE      32'h1100_0000  base of IO window; low 8 bits of IOBUS_ADDR select the register
//  SW_W         16             switch input width
//  LED_W        16             LED register width
//  SYNC_STAGES  2              flops in switch synchroniser (>=2)
// PORTS
//  CLK        in   1      single clock, rising edge
//  RST        in   1      synchronous, active-high reset
//  IOBUS_ADDR in   32     byte address from memory stage (word aligned; bits[1:0] ignored)
//  IOBUS_OUT  in   32     write data (MEM_DIN2)
//  IOBUS_WR   in   1      word write strobe, one cycle per store
//  IOBUS_IN   out  32     read data, combinational from IOBUS_ADDR (memory stage registers it)
//  SWITCHES   in   SW_W   asynchronous board switches
//  LEDS       out  LED_W  LED register
//  SSEG       out  16     seven-seg display value register
//  INTR       out  1      timer interrupt = FLAG & IRQ_EN, level
// BEHAVIOUR
//  - Register map, offsets from IO_BASE:
//    00 SW (RO, synced, zero-extended)
//    20 LED (RW)
//    40 SSEG (RW)
//    60 TCNT (RW)
//    64 TCMP (RW)
//    68 TPRE (RW)
//    6C TCTRL: b0 EN, b1 AUTOCLR, b2 IRQ_EN (RW); b3 FLAG (RO, write-1-to-clear)
//  - Hit = IOBUS_ADDR[31:8]==IO_BASE[31:8] and offset mapped.
//  - Misses: reads return 0; writes ignored. Reads have no side effects.
//  - Writes take effect at the CLK edge when IOBUS_WR=1. Wider-than-field data is truncated; unused read bits are 0.
//  - Reset: LEDS=0, SSEG=0, TCNT=0, TCMP=32'hFFFF_FFFF, TPRE=0, TCTRL=0, prescale counter=0, sync chain=0, INTR=0.
//  - Switches: SW reads the SYNC_STAGES-delayed value, so latency is SYNC_STAGES cycles.
//  - Prescaler PC counts 0..TPRE while EN=1. tick = EN & (PC==TPRE); PC wraps to 0 on tick. PC is held at 0 while EN=0.
//  - On tick:
//    - if TCNT==TCMP: FLAG<=1, and TCNT<=0 if AUTOCLR else TCNT+1.
//    - otherwise TCNT<=TCNT+1. TCNT wraps FFFF_FFFF -> 0 with no flag.
//  - Same-cycle write to TCNT and tick: match is evaluated on the old TCNT (FLAG may set), then the written value loads (write wins).
//  - Write to TPRE resets PC to 0.
//  - Same-cycle FLAG W1C and FLAG set: set wins.
//  - INTR changes one cycle after FLAG or IRQ_EN is updated (registered).
//  - RST mid-count: all state returns to reset values on the next edge. A pending FLAG is lost.
// STRUCTURE
//  - otter_io_pkg holds the register offset localparams, TCTRL bit indices, and the typedef io_timer_ctrl_t (packed EN/AUTOCLR/IRQ_EN/FLAG).
//  - One sub-module, otter_io_timer, contains TCNT/TCMP/TPRE/PC/FLAG.
//    - Inputs: write strobes and data.
//    - Outputs: register values and INTR.
//  - Top level contains the address decode, read mux, LED/SSEG registers and the switch synchroniser.
// TESTING
//  1. Reset, then read every offset -> SW=0, LED=0, SSEG=0, TCNT=0, TCMP=FFFF_FFFF, TPRE=0, TCTRL=0; INTR=0.
//  2. Write LED=0xFFFF_A5A5 at 0x1100_0020 -> LEDS=16'hA5A5 next cycle, read back 0x0000_A5A5. Write 0x1200_0020 -> LEDS unchanged.
//  3. Set SWITCHES=16'h1234 -> SW read returns 0 for cycles 0-1, then 0x1234 from cycle 2 (SYNC_STAGES=2).
//  4. TCMP=3, TPRE=1, TCTRL=EN|AUTOCLR|IRQ_EN -> TCNT advances every 2 cycles 0,1,2,3,0. FLAG sets on the 3->0 tick; INTR=1 one cycle later.
//  5. With FLAG=1: write TCTRL with b3=1 in the same cycle as a match tick -> FLAG stays 1. Repeat with no tick -> FLAG=0 and INTR=0 next cycle.
//  6. TCNT=FFFF_FFFF, TPRE=0, EN -> next tick TCNT=0 with FLAG unchanged. Write TCNT=5 coincident with a tick -> TCNT=5. Assert RST mid-count -> all reset values.

Source files
------------

// File: rtl/otter_io_pkg.sv
// Shared register map, TCTRL bit layout and reset constants for the OTTER IO responder.
package otter_io_pkg;

  localparam logic [7:0] OFF_SW    = 8'h00;
  localparam logic [7:0] OFF_LED   = 8'h20;
  localparam logic [7:0] OFF_SSEG  = 8'h40;
  localparam logic [7:0] OFF_TCNT  = 8'h60;
  localparam logic [7:0] OFF_TCMP  = 8'h64;
  localparam logic [7:0] OFF_TPRE  = 8'h68;
  localparam logic [7:0] OFF_TCTRL = 8'h6C;

  localparam int unsigned TCTRL_EN      = 0;
  localparam int unsigned TCTRL_AUTOCLR = 1;
  localparam int unsigned TCTRL_IRQ_EN  = 2;
  localparam int unsigned TCTRL_FLAG    = 3;

  localparam logic [31:0] TCMP_RESET = 32'hFFFF_FFFF;

  // Field order makes the packed value line up with the TCTRL bit indices.
  typedef struct packed {
    logic flag;
    logic irq_en;
    logic autoclr;
    logic en;
  } io_timer_ctrl_t;

endpackage

// File: rtl/otter_io_timer.sv
// Prescaled compare timer: TCNT/TCMP/TPRE, prescale counter, sticky FLAG and registered INTR.
module otter_io_timer
  import otter_io_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_tcnt,
  input  logic           wr_tcmp,
  input  logic           wr_tpre,
  input  logic           wr_tctrl,
  input  logic [31:0]    wdata,
  output logic [31:0]    tcnt,
  output logic [31:0]    tcmp,
  output logic [31:0]    tpre,
  output io_timer_ctrl_t ctrl,
  output logic           intr
);

  logic [31:0]    tcnt_r;
  logic [31:0]    tcmp_r;
  logic [31:0]    tpre_r;
  logic [31:0]    pc_r;
  io_timer_ctrl_t ctrl_r;
  logic           intr_r;
  logic           tick_s;
  logic           match_s;
  logic           flag_set_s;

  // Tick and compare are judged on the pre-edge register values.
  always_comb begin
    tick_s     = ctrl_r.en && (pc_r == tpre_r);
    match_s    = (tcnt_r == tcmp_r);
    flag_set_s = tick_s && match_s;
  end

  // Timer state update; a software TCNT write overrides the tick result, FLAG set beats W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_r <= 32'd0;
      tcmp_r <= TCMP_RESET;
      tpre_r <= 32'd0;
      pc_r   <= 32'd0;
      ctrl_r <= '0;
      intr_r <= 1'b0;
    end else begin
      if (wr_tpre || !ctrl_r.en || tick_s) begin
        pc_r <= 32'd0;
      end else begin
        pc_r <= pc_r + 32'd1;
      end

      if (wr_tcnt) begin
        tcnt_r <= wdata;
      end else if (flag_set_s && ctrl_r.autoclr) begin
        tcnt_r <= 32'd0;
      end else if (tick_s) begin
        tcnt_r <= tcnt_r + 32'd1;
      end else begin
        tcnt_r <= tcnt_r;
      end

      if (wr_tcmp) begin
        tcmp_r <= wdata;
      end else begin
        tcmp_r <= tcmp_r;
      end

      if (wr_tpre) begin
        tpre_r <= wdata;
      end else begin
        tpre_r <= tpre_r;
      end

      if (wr_tctrl) begin
        ctrl_r.en      <= wdata[TCTRL_EN];
        ctrl_r.autoclr <= wdata[TCTRL_AUTOCLR];
        ctrl_r.irq_en  <= wdata[TCTRL_IRQ_EN];
      end else begin
        ctrl_r.en      <= ctrl_r.en;
        ctrl_r.autoclr <= ctrl_r.autoclr;
        ctrl_r.irq_en  <= ctrl_r.irq_en;
      end

      if (flag_set_s) begin
        ctrl_r.flag <= 1'b1;
      end else if (wr_tctrl && wdata[TCTRL_FLAG]) begin
        ctrl_r.flag <= 1'b0;
      end else begin
        ctrl_r.flag <= ctrl_r.flag;
      end

      intr_r <= ctrl_r.flag && ctrl_r.irq_en;
    end
  end

  assign tcnt = tcnt_r;
  assign tcmp = tcmp_r;
  assign tpre = tpre_r;
  assign ctrl = ctrl_r;
  assign intr = intr_r;

endmodule

// File: rtl/otter_io_responder.sv
// OTTER IOBUS responder: address decode, read mux, LED/SSEG registers, switch synchroniser and timer.
module otter_io_responder
  import otter_io_pkg::*;
#(
  parameter logic [31:0] IO_BASE     = 32'h1100_0000,
  parameter int          SW_W        = 16,
  parameter int          LED_W       = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      IOBUS_ADDR,
  input  logic [31:0]      IOBUS_OUT,
  input  logic             IOBUS_WR,
  output logic [31:0]      IOBUS_IN,
  input  logic [SW_W-1:0]  SWITCHES,
  output logic [LED_W-1:0] LEDS,
  output logic [15:0]      SSEG,
  output logic             INTR
);

  logic [SW_W-1:0]  sync_r [SYNC_STAGES];
  logic [LED_W-1:0] leds_r;
  logic [15:0]      sseg_r;
  logic             base_hit_s;
  logic [5:0]       word_off_s;
  logic             wr_led_s, wr_sseg_s, wr_tcnt_s, wr_tcmp_s, wr_tpre_s, wr_tctrl_s;
  logic [31:0]      tcnt_s, tcmp_s, tpre_s;
  io_timer_ctrl_t   ctrl_s;
  logic [1:0]       unused_addr_s;

  assign base_hit_s    = (IOBUS_ADDR[31:8] == IO_BASE[31:8]);
  assign word_off_s    = IOBUS_ADDR[7:2];
  assign unused_addr_s = IOBUS_ADDR[1:0];

  // Write strobe decode and combinational read mux; unmapped offsets read 0 and ignore writes.
  always_comb begin
    wr_led_s   = 1'b0;
    wr_sseg_s  = 1'b0;
    wr_tcnt_s  = 1'b0;
    wr_tcmp_s  = 1'b0;
    wr_tpre_s  = 1'b0;
    wr_tctrl_s = 1'b0;
    IOBUS_IN   = 32'd0;
    if (base_hit_s) begin
      case (word_off_s)
        OFF_SW[7:2]:    IOBUS_IN = 32'(sync_r[SYNC_STAGES-1]);
        OFF_LED[7:2]:   begin IOBUS_IN = 32'(leds_r);  wr_led_s   = IOBUS_WR; end
        OFF_SSEG[7:2]:  begin IOBUS_IN = {16'd0, sseg_r}; wr_sseg_s = IOBUS_WR; end
        OFF_TCNT[7:2]:  begin IOBUS_IN = tcnt_s;       wr_tcnt_s  = IOBUS_WR; end
        OFF_TCMP[7:2]:  begin IOBUS_IN = tcmp_s;       wr_tcmp_s  = IOBUS_WR; end
        OFF_TPRE[7:2]:  begin IOBUS_IN = tpre_s;       wr_tpre_s  = IOBUS_WR; end
        OFF_TCTRL[7:2]: begin IOBUS_IN = {28'd0, ctrl_s}; wr_tctrl_s = IOBUS_WR; end
        default:        IOBUS_IN = 32'd0;
      endcase
    end else begin
      IOBUS_IN = 32'd0;
    end
  end

  // Board-facing registers and the switch synchroniser chain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      leds_r <= '0;
      sseg_r <= 16'd0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      leds_r    <= wr_led_s  ? IOBUS_OUT[LED_W-1:0] : leds_r;
      sseg_r    <= wr_sseg_s ? IOBUS_OUT[15:0]      : sseg_r;
      sync_r[0] <= SWITCHES;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  otter_io_timer u_timer (
    .clk      (CLK),
    .rst      (RST),
    .wr_tcnt  (wr_tcnt_s),
    .wr_tcmp  (wr_tcmp_s),
    .wr_tpre  (wr_tpre_s),
    .wr_tctrl (wr_tctrl_s),
    .wdata    (IOBUS_OUT),
    .tcnt     (tcnt_s),
    .tcmp     (tcmp_s),
    .tpre     (tpre_s),
    .ctrl     (ctrl_s),
    .intr     (INTR)
  );

  assign LEDS = leds_r;
  assign SSEG = sseg_r;

endmodule
